// File: rtl/mux_scan_ctrl.sv
// Scan controller for a registered 4:1 mux stage: visits each enabled channel in ascending order and captures its bit.
// Latency: 1 + popcount(mask)*(2+SETTLE) cycles from start accept to the done pulse.
// Backpressure: none; start is accepted only in IDLE and ignored otherwise.
//
// Ports:
//   clk      system clock, rising edge
//   resetn   synchronous reset, active HIGH (name kept from the codebase)
//   start    scan request, accepted only in IDLE
//   mask     channel enables, latched on accept
//   q_in     registered output of the mux stage
//   sel      registered channel select to the mux stage
//   busy     high during DRIVE/WAIT/CAPTURE
//   done     one-cycle pulse on scan completion
//   result   captured bits, bit k = channel k, unmasked bits read 0
module mux_scan_ctrl #(
    parameter int SETTLE = 0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [3:0] mask,
    input  logic       q_in,
    output logic [1:0] sel,
    output logic       busy,
    output logic       done,
    output logic [3:0] result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    // WAIT counter reload; clamped so SETTLE=0 does not underflow (WAIT is skipped then).
    localparam logic [3:0] SETTLE_M1 = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    state_t     state_q, state_d;
    logic [3:0] mask_q, mask_d;
    logic [3:0] result_q, result_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] sel_q, sel_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [2:0] first_ch;
    logic [2:0] next_ch;

    // Lowest enabled channel with index >= from. Returns {found, index}.
    function automatic logic [2:0] find_ch(input logic [3:0] m, input logic [2:0] from);
        logic [2:0] r;
        r = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            if (m[k] && (3'(k) >= from)) begin
                r = {1'b1, 2'(k)};
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        first_ch = find_ch(mask, 3'd0);
        next_ch  = find_ch(mask_q, {1'b0, sel_q} + 3'd1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d   = mask;
                    result_d = 4'd0;
                    if (first_ch[2]) begin
                        sel_d   = first_ch[1:0];
                        state_d = S_DRIVE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DRIVE: begin
                if (SETTLE > 0) begin
                    cnt_d   = SETTLE_M1;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_CAPTURE: begin
                // The mux register has held channel sel_q's bit since the cycle after DRIVE.
                result_d[sel_q] = q_in;
                if (next_ch[2]) begin
                    sel_d   = next_ch[1:0];
                    state_d = S_DRIVE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered copies of the upcoming state.
        busy_d = (state_d == S_DRIVE) || (state_d == S_WAIT) || (state_d == S_CAPTURE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q  <= S_IDLE;
            mask_q   <= 4'd0;
            result_q <= 4'd0;
            cnt_q    <= 4'd0;
            sel_q    <= 2'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign sel    = sel_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (SETTLE=0 and SETTLE=2) each driving a registered 4:1 mux model.
// Expected sel trace, done latency and result word come from the channel-visit rules, not the FSM.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v   [2];
    logic       start_v [2];
    logic [3:0] mask_v  [2];
    logic [3:0] pat_v   [2];
    logic       q_v     [2];
    logic [1:0] sel_v   [2];
    logic       busy_v  [2];
    logic       done_v  [2];
    logic [3:0] result_v[2];

    int errors = 0;
    int checks = 0;

    mux_scan_ctrl #(.SETTLE(0)) u_dut0 (
        .clk(clk), .resetn(rst_v[0]), .start(start_v[0]), .mask(mask_v[0]), .q_in(q_v[0]),
        .sel(sel_v[0]), .busy(busy_v[0]), .done(done_v[0]), .result(result_v[0])
    );

    mux_scan_ctrl #(.SETTLE(2)) u_dut2 (
        .clk(clk), .resetn(rst_v[1]), .start(start_v[1]), .mask(mask_v[1]), .q_in(q_v[1]),
        .sel(sel_v[1]), .busy(busy_v[1]), .done(done_v[1]), .result(result_v[1])
    );

    // Registered 4:1 mux stages fed by the per-instance input pattern.
    always @(posedge clk) begin
        q_v[0] <= pat_v[0][sel_v[0]];
        q_v[1] <= pat_v[1][sel_v[1]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One scan on instance d; noisy pulses start and scrambles mask while the scan runs and in the DONE cycle.
    task automatic run_scan(input int d, input logic [3:0] m, input logic [3:0] pat, input bit noisy);
        int         s;
        int         n;
        int         lat;
        int         exp_sel[$];
        int         done_cyc;
        int         done_cnt;
        logic [3:0] exp_res;
        s        = (d == 0) ? 0 : 2;
        n        = $countones(m);
        lat      = 1 + n * (2 + s);
        exp_res  = m & pat;
        done_cyc = -1;
        done_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (m[k]) begin
                for (int r = 0; r < 2 + s; r++) exp_sel.push_back(k);
            end
        end

        @(negedge clk);
        pat_v[d]   = pat;
        mask_v[d]  = m;
        start_v[d] = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= lat + 2; cyc++) begin
            @(negedge clk);
            start_v[d] = 1'b0;
            if (done_v[d] === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            check("busy_done_excl", 32'(busy_v[d] & done_v[d]), 32'd0);
            if (cyc < lat) begin
                check("busy_scan", 32'(busy_v[d]), 32'd1);
                check("sel_trace", 32'(sel_v[d]), 32'(exp_sel[cyc-1]));
            end else begin
                check("busy_idle", 32'(busy_v[d]), 32'd0);
                check("result", 32'(result_v[d]), 32'(exp_res));
            end
            if (noisy && cyc <= lat) begin
                start_v[d] = 1'($urandom_range(0, 1));
                mask_v[d]  = 4'($urandom);
            end
        end
        check("done_latency", 32'(done_cyc), 32'(lat));
        check("done_count", 32'(done_cnt), 32'd1);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_v[d]   = 1'b1;
            start_v[d] = 1'b1;
            mask_v[d]  = 4'hF;
            pat_v[d]   = 4'h0;
        end

        // Reset held 2 cycles with start high: nothing may start.
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_sel", 32'(sel_v[d]), 32'd0);
            check("rst_busy", 32'(busy_v[d]), 32'd0);
            check("rst_done", 32'(done_v[d]), 32'd0);
            check("rst_result", 32'(result_v[d]), 32'd0);
            rst_v[d]   = 1'b0;
            start_v[d] = 1'b0;
        end
        @(negedge clk);
        check("post_rst_busy0", 32'(busy_v[0]), 32'd0);
        check("post_rst_busy2", 32'(busy_v[1]), 32'd0);

        // Full scan, i0..i3 = 1,0,1,1.
        run_scan(0, 4'b1111, 4'b1101, 1'b0);
        // Sparse scan with settle.
        run_scan(1, 4'b1010, 4'b1111, 1'b0);
        run_scan(1, 4'b1010, 4'b0101, 1'b0);
        // Empty mask.
        run_scan(0, 4'b0000, 4'hF, 1'b0);
        run_scan(1, 4'b0000, 4'hF, 1'b0);
        // Ignored start and mask changes.
        run_scan(0, 4'b1111, 4'b1010, 1'b1);
        run_scan(1, 4'b1011, 4'b0110, 1'b1);

        // Reset during CAPTURE of channel 2 (cycle 6 after accept with SETTLE=0).
        @(negedge clk);
        pat_v[0]   = 4'hF;
        mask_v[0]  = 4'b1111;
        start_v[0] = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            start_v[0] = 1'b0;
        end
        check("mid_sel_before_rst", 32'(sel_v[0]), 32'd2);
        rst_v[0] = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy_v[0]), 32'd0);
        check("mid_rst_done", 32'(done_v[0]), 32'd0);
        check("mid_rst_result", 32'(result_v[0]), 32'd0);
        check("mid_rst_sel", 32'(sel_v[0]), 32'd0);
        rst_v[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("mid_rst_no_done", 32'(done_v[0]), 32'd0);
        end
        run_scan(0, 4'b0100, 4'b0100, 1'b0);

        // Randomized scans on both instances.
        for (int i = 0; i < 40; i++) begin
            run_scan(i % 2, 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
